// File: rtl/vc_plane_arbiter_pkg.sv
// Shared definitions for the crossbar plane arbiter: FSM encoding and
// the index-width helper used to size plane indices.
package vc_plane_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    // $clog2 that never returns 0, so a single-plane build still has a 1-bit index
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vc_plane_arbiter_if.sv
// Request/transfer inputs from the VC planes and the plane-select outputs
// that steer the shared crossbar.
interface vc_plane_arbiter_if
    import vc_plane_arbiter_pkg::*;
#(
    parameter int VC   = 4,
    parameter int VC_W = clog2_min1(VC)
) ();

    logic [VC-1:0]   vc_req;
    logic [VC-1:0]   vc_xfer;
    logic [VC-1:0]   vc_tail;
    logic [VC:0]     VCPlaneSelector;
    logic [VC_W-1:0] active_vc;
    logic            grant_valid;
    logic            protocol_err;

    modport master (
        output vc_req, vc_xfer, vc_tail,
        input  VCPlaneSelector, active_vc, grant_valid, protocol_err
    );

    modport slave (
        input  vc_req, vc_xfer, vc_tail,
        output VCPlaneSelector, active_vc, grant_valid, protocol_err
    );

endinterface

// File: rtl/vc_plane_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request bit at or after the
// start index, wrapping around, so the plane just below start is checked last.
module rr_priority_picker
    import vc_plane_arbiter_pkg::*;
#(
    parameter int VC   = 4,
    parameter int VC_W = clog2_min1(VC)
) (
    input  logic [VC-1:0]   i_req,
    input  logic [VC_W-1:0] i_start,
    output logic            o_found,
    output logic [VC_W-1:0] o_idx
);

    logic [2*VC-1:0] w_dbl;
    logic [VC-1:0]   w_rot;
    int              w_ofs;

    assign w_dbl = {i_req, i_req};
    assign w_rot = VC'(w_dbl >> i_start);

    // lowest set bit of the rotated vector is the winner's distance from start
    always_comb begin
        w_ofs = 0;
        for (int k = VC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_ofs = k;
            end
        end
        o_found = |w_rot;
        o_idx   = VC_W'((int'(i_start) + w_ofs) % VC);
    end

endmodule

// File: rtl/vc_plane_arbiter.sv
// Work-conserving round-robin owner of the shared crossbar. A plane keeps
// the grant until its tail passes, its flit quantum is used up, or it stays
// quiet too long; the next requester is then granted without a bubble.
module vc_plane_arbiter
    import vc_plane_arbiter_pkg::*;
#(
    parameter int VC           = 4,
    parameter int QUANTUM      = 6,
    parameter int IDLE_TIMEOUT = 4,
    parameter int VC_W         = clog2_min1(VC)
) (
    input logic               clk,
    input logic               rst,
    vc_plane_arbiter_if.slave bus
);

    localparam int CNT_W  = clog2_min1(QUANTUM + 1);
    localparam int ICNT_W = clog2_min1(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0]  XFER_LAST = CNT_W'(QUANTUM - 1);
    localparam logic [CNT_W-1:0]  XFER_MAX  = CNT_W'(QUANTUM);
    localparam logic [ICNT_W-1:0] IDLE_LAST = ICNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [VC_W-1:0]   LAST_VC   = VC_W'(VC - 1);

    state_e            r_state, w_nxt_state;
    logic [VC_W-1:0]   r_gnt, w_nxt_gnt;
    logic [VC_W-1:0]   r_ptr, w_nxt_ptr;
    logic [CNT_W-1:0]  r_xcnt, w_nxt_xcnt;
    logic [ICNT_W-1:0] r_icnt, w_nxt_icnt;
    logic [VC:0]       r_sel, w_nxt_sel;
    logic              r_gvalid;
    logic              r_perr;

    logic [VC_W-1:0]   w_gnt_inc;
    logic [VC_W-1:0]   w_start;
    logic [VC_W-1:0]   w_pick_idx;
    logic              w_pick_found;
    logic              w_req_g, w_xfer_g, w_tail_g;
    logic              w_release;
    logic              w_bad_xfer;

    assign w_req_g   = bus.vc_req[r_gnt];
    assign w_xfer_g  = bus.vc_xfer[r_gnt];
    assign w_tail_g  = bus.vc_tail[r_gnt];
    assign w_gnt_inc = (r_gnt == LAST_VC) ? '0 : r_gnt + VC_W'(1);

    // Tail and quantum expiry landing together are one release by construction.
    assign w_release = (r_state == ST_SERVE) &&
                       ((w_xfer_g && w_tail_g) ||
                        (w_xfer_g && (r_xcnt == XFER_LAST)) ||
                        (!w_req_g && (r_icnt == IDLE_LAST)));

    // From idle, scan from the pointer; on release, scan past the current owner.
    assign w_start = (r_state == ST_IDLE) ? r_ptr : w_gnt_inc;

    // Any transfer outside the granted plane means a plane ignored the select.
    assign w_bad_xfer = |(bus.vc_xfer & ~r_sel[VC-1:0]);

    rr_priority_picker #(.VC(VC), .VC_W(VC_W)) u_pick (
        .i_req   (bus.vc_req),
        .i_start (w_start),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // Next grant, pointer and per-grant counters.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_ptr   = r_ptr;
        w_nxt_xcnt  = r_xcnt;
        w_nxt_icnt  = r_icnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_nxt_state = ST_SERVE;
                    w_nxt_gnt   = w_pick_idx;
                    w_nxt_xcnt  = '0;
                    w_nxt_icnt  = '0;
                end
            end
            ST_SERVE: begin
                if (w_release) begin
                    w_nxt_ptr  = w_gnt_inc;
                    w_nxt_xcnt = '0;
                    w_nxt_icnt = '0;
                    if (w_pick_found) begin
                        w_nxt_gnt = w_pick_idx;
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_gnt   = '0;
                    end
                end else begin
                    if (w_xfer_g && (r_xcnt != XFER_MAX)) begin
                        w_nxt_xcnt = r_xcnt + CNT_W'(1);
                    end
                    w_nxt_icnt = w_req_g ? '0 : r_icnt + ICNT_W'(1);
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
        w_nxt_sel = '0;
        if (w_nxt_state == ST_SERVE) begin
            w_nxt_sel[w_nxt_gnt] = 1'b1;
        end else begin
            w_nxt_sel[VC] = 1'b1;
        end
    end

    // State and registered outputs; protocol error is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_ptr    <= '0;
            r_xcnt   <= '0;
            r_icnt   <= '0;
            r_sel    <= {1'b1, {VC{1'b0}}};
            r_gvalid <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_gnt    <= w_nxt_gnt;
            r_ptr    <= w_nxt_ptr;
            r_xcnt   <= w_nxt_xcnt;
            r_icnt   <= w_nxt_icnt;
            r_sel    <= w_nxt_sel;
            r_gvalid <= (w_nxt_state == ST_SERVE);
            r_perr   <= r_perr | w_bad_xfer;
        end
    end

    assign bus.VCPlaneSelector = r_sel;
    assign bus.active_vc       = r_gnt;
    assign bus.grant_valid     = r_gvalid;
    assign bus.protocol_err    = r_perr;

endmodule
